// File: rtl/data_memory_if.sv
// Request/response bundle between the MIPS datapath and the data memory stage.
// The master drives the access; the memory returns load data and the fault flag.
interface data_memory_if;
    logic [31:0] pc;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  DMop;
    logic [31:0] addr;
    logic [31:0] WD;
    logic [31:0] DM_WB;
    logic        err;

    modport master (
        output pc, MemWrite, MemRead, DMop, addr, WD,
        input  DM_WB, err
    );

    modport slave (
        input  pc, MemWrite, MemRead, DMop, addr, WD,
        output DM_WB, err
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM with byte/half/word store merging, sign/zero-extending
// loads and a registered access-fault flag.
module data_memory #(
    parameter int unsigned DEPTH = 3072
) (
    input  logic          clk,
    input  logic          reset,
    data_memory_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OP_W   = 3'b000;
    localparam logic [2:0] OP_B   = 3'b001;
    localparam logic [2:0] OP_BU  = 3'b010;
    localparam logic [2:0] OP_H   = 3'b011;
    localparam logic [2:0] OP_HU  = 3'b100;

    logic [31:0]      r_mem [DEPTH];
    logic             r_err;

    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic             w_aligned;
    logic             w_op_ok;
    logic             w_valid;
    logic [4:0]       w_lane_lsb;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_merged;

    assign w_idx      = bus.addr[IDX_W+1:2];
    // Full 30-bit index compare so addresses at or above 4*DEPTH never alias low words.
    assign w_in_range = (bus.addr[31:2] < 30'(DEPTH));
    assign w_lane_lsb = {bus.addr[1:0], 3'b000};

    always_comb begin
        w_aligned = 1'b0;
        w_op_ok   = 1'b1;
        case (bus.DMop)
            OP_W:         w_aligned = (bus.addr[1:0] == 2'b00);
            OP_B, OP_BU:  w_aligned = 1'b1;
            OP_H, OP_HU:  w_aligned = ~bus.addr[0];
            default:      w_op_ok   = 1'b0;
        endcase
    end

    assign w_valid = w_in_range & w_aligned & w_op_ok;
    assign w_word  = w_in_range ? r_mem[w_idx] : 32'h0;
    assign w_byte  = w_word[w_lane_lsb +: 8];
    assign w_half  = bus.addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'h0;
        case (bus.DMop)
            OP_W:    w_load = w_word;
            OP_B:    w_load = {{24{w_byte[7]}}, w_byte};
            OP_BU:   w_load = {24'h0, w_byte};
            OP_H:    w_load = {{16{w_half[15]}}, w_half};
            OP_HU:   w_load = {16'h0, w_half};
            default: w_load = 32'h0;
        endcase
    end

    assign bus.DM_WB = (reset || !w_valid) ? 32'h0 : w_load;
    assign bus.err   = r_err;

    always_comb begin
        w_merged = w_word;
        case (bus.DMop)
            OP_W:        w_merged = bus.WD;
            OP_B, OP_BU: w_merged[w_lane_lsb +: 8] = bus.WD[7:0];
            OP_H, OP_HU: begin
                if (bus.addr[1]) w_merged[31:16] = bus.WD[15:0];
                else             w_merged[15:0]  = bus.WD[15:0];
            end
            default:     w_merged = w_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every word is cleared on reset, so this array maps to flops, not a RAM macro.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
            r_err <= 1'b0;
        end else begin
            r_err <= (bus.MemWrite | bus.MemRead) & ~w_valid;
            if (bus.MemWrite && w_valid) begin
                r_mem[w_idx] <= w_merged;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && bus.MemWrite && w_valid) begin
            $display("@%h: *%h <= %h", bus.pc, {bus.addr[31:2], 2'b00}, w_merged);
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory: store merging, load extension,
// fault flag timing, boundary addresses and asynchronous reset.
module tb_data_memory;

    logic clk;
    logic reset;
    data_memory_if bus ();

    data_memory #(.DEPTH(3072)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.we = we; v.re = re; v.op = op; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic we, input logic re, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.MemWrite = we;
        bus.MemRead  = re;
        bus.DMop     = op;
        bus.addr     = addr;
        bus.WD       = wd;
    endtask

    initial begin
        // exp_rd is the combinational load value before the edge; exp_err is err after it.
        add(1, 0, 3'b000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0); // SW 0
        add(0, 1, 3'b000, 32'h0000_0000, 32'h0,         32'h1234_5678, 0); // LW 0
        add(1, 0, 3'b001, 32'h0000_0001, 32'hFFFF_FFAB, 32'h0000_0056, 0); // SB 1
        add(0, 1, 3'b000, 32'h0000_0000, 32'h0,         32'h1234_AB78, 0);
        add(0, 1, 3'b001, 32'h0000_0001, 32'h0,         32'hFFFF_FFAB, 0); // LB
        add(0, 1, 3'b010, 32'h0000_0001, 32'h0,         32'h0000_00AB, 0); // LBU
        add(1, 0, 3'b011, 32'h0000_0006, 32'h0000_8001, 32'h0000_0000, 0); // SH 6
        add(0, 1, 3'b000, 32'h0000_0004, 32'h0,         32'h8001_0000, 0);
        add(0, 1, 3'b011, 32'h0000_0006, 32'h0,         32'hFFFF_8001, 0); // LH
        add(0, 1, 3'b100, 32'h0000_0006, 32'h0,         32'h0000_8001, 0); // LHU
        add(0, 1, 3'b011, 32'h0000_0004, 32'h0,         32'h0000_0000, 0);
        add(1, 0, 3'b000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1); // misaligned SW
        add(0, 1, 3'b000, 32'h0000_0000, 32'h0,         32'h1234_AB78, 0);
        add(0, 1, 3'b011, 32'h0000_0003, 32'h0,         32'h0000_0000, 1); // misaligned LH
        add(0, 1, 3'b000, 32'h0000_3000, 32'h0,         32'h0000_0000, 1); // out of range
        add(1, 0, 3'b101, 32'h0000_0000, 32'hCAFE_BABE, 32'h0000_0000, 1); // reserved op
        add(0, 1, 3'b000, 32'h0000_0000, 32'h0,         32'h1234_AB78, 0);
        add(1, 0, 3'b000, 32'h0000_2FFC, 32'hDEAD_BEEF, 32'h0000_0000, 0); // top word
        add(0, 1, 3'b000, 32'h0000_2FFC, 32'h0,         32'hDEAD_BEEF, 0);
        add(0, 1, 3'b000, 32'h0000_3000, 32'h0,         32'h0000_0000, 1); // no wrap
        add(0, 0, 3'b000, 32'h0000_0000, 32'h0,         32'h1234_AB78, 0); // idle read
        add(0, 0, 3'b000, 32'h0000_0002, 32'h0,         32'h0000_0000, 0); // idle fault addr
        add(1, 1, 3'b010, 32'h0000_0003, 32'h0000_00C3, 32'h0000_0012, 0); // SB via 010
        add(0, 1, 3'b000, 32'h0000_0000, 32'h0,         32'hC334_AB78, 0);
        add(1, 0, 3'b100, 32'h0000_0002, 32'h0000_7E5A, 32'h0000_C334, 0); // SH via 100
        add(0, 1, 3'b000, 32'h0000_0000, 32'h0,         32'h7E5A_AB78, 0);
        add(0, 1, 3'b011, 32'h0000_0002, 32'h0,         32'h0000_7E5A, 0);

        bus.pc = 32'h0040_0000;
        drive(0, 0, 3'b000, 32'h0, 32'h0);
        reset = 1'b1;
        #2;
        check("reset err", {31'h0, bus.err}, 32'h0);
        check("reset rd", bus.DM_WB, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.pc = 32'h0040_0000 + 32'(i * 4);
            drive(vecs[i].we, vecs[i].re, vecs[i].op, vecs[i].addr, vecs[i].wd);
            #1;
            check($sformatf("vec%0d rd", i), bus.DM_WB, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d err", i), {31'h0, bus.err}, {31'h0, vecs[i].exp_err});
        end

        // Read-during-write: old data before the edge, new data after it.
        drive(1, 1, 3'b000, 32'h0000_0008, 32'h1122_3344);
        #1 check("rdw before", bus.DM_WB, 32'h0);
        @(posedge clk);
        #1 check("rdw after", bus.DM_WB, 32'h1122_3344);

        // Raise err, then assert reset mid-cycle with a store pending.
        drive(0, 1, 3'b000, 32'h0000_0001, 32'h0);
        @(posedge clk);
        #1 check("pre-reset err", {31'h0, bus.err}, 32'h1);
        drive(1, 0, 3'b000, 32'h0000_0000, 32'hFFFF_FFFF);
        #1 check("pre-reset rd", bus.DM_WB, 32'h7E5A_AB78);
        #1 reset = 1'b1;
        #1;
        check("async err", {31'h0, bus.err}, 32'h0);
        check("async rd", bus.DM_WB, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(0, 1, 3'b000, 32'h0000_0000, 32'h0);
        #1 check("dropped store", bus.DM_WB, 32'h0);
        drive(0, 1, 3'b000, 32'h0000_2FFC, 32'h0);
        #1 check("cleared top", bus.DM_WB, 32'h0);
        drive(0, 1, 3'b000, 32'h0000_0008, 32'h0);
        #1 check("cleared w2", bus.DM_WB, 32'h0);
        @(posedge clk);
        #1 check("post-reset err", {31'h0, bus.err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Data memory stage for the single-cycle/pipelined MIPS datapath: a word-organised RAM with byte/half/word store merging and load extraction with sign/zero extension. It sits directly upstream of the write-back selector: its load result `DM_WB` is the memory-sourced candidate for register write-back. Stores commit on the clock edge. A registered error flag reports misaligned, out-of-range and reserved-op accesses.

## Interface
- `DEPTH`, 3072: number of 32-bit words; the valid byte address range is 0 to 4*DEPTH-1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  32  PC of the instruction in this stage; used only for the write log.
- `MemWrite`  in  1  store request this cycle.
- `MemRead`  in  1  load request this cycle; only affects `err`.
- `DMop`  in  3  access width/extension: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned, 101–111 reserved.
- `addr`  in  32  byte address from the ALU.
- `WD`  in  32  store data; the low byte, low half or full word is used according to `DMop`.
- `DM_WB`  out  32  load result, extended to 32 bits.
- `err`  out  1  registered access-fault flag.

## Operation
- Word index is `addr[31:2]`. The access is in range when the index is less than `DEPTH`.
- Alignment:
  - Word access requires `addr[1:0]==0`.
  - Half access requires `addr[0]==0`.
  - Byte access is always aligned.
- The access is valid when it is in range, aligned and `DMop` is not reserved.
- Load path is combinational from the array:
  - Byte ops select byte `addr[1:0]`; byte 0 is bits [7:0] (little-endian within the word).
  - Half ops select bits [15:0] when `addr[1]==0`, and bits [31:16] otherwise.
  - Signed ops replicate the top bit of the selected field. Unsigned ops zero-fill.
  - An invalid access drives `DM_WB=0`.
- Store path: on a rising edge with `MemWrite=1`, a valid access and `reset=0`, the selected lanes are replaced with the low bits of `WD` and all other lanes are preserved.
  - Sign is ignored for stores; 001 and 010 both act as SB, and 011 and 100 both act as SH.
- An invalid store leaves the memory unchanged.
- Every committed store emits the simulation log line `@<pc hex>: *<word-aligned addr hex> <= <merged word hex>`. The log is excluded from synthesis.
- `err` is updated every edge: `err <= (MemWrite|MemRead) & !valid`. It is high for exactly the cycle following a faulting access.
- `MemWrite` and `MemRead` both high is legal: the store commits and `DM_WB` shows the pre-store data until the edge.

## Timing
- Reset (asynchronous, takes effect immediately without a clock edge):
  - All `DEPTH` words become 0 and `err` becomes 0.
  - `DM_WB` reads 0 while `reset` is high.
  - A store coinciding with `reset` is dropped.
- Load latency is 0 cycles; `DM_WB` follows `addr`/`DMop` combinationally.
- Store latency is 1 edge. A load of the same address in the next cycle returns the new data.
- Read-during-write at the same address: the old value is visible until the edge, and the new value after it.
- Boundary addresses:
  - Word at byte address 4*DEPTH-4 is valid.
  - 4*DEPTH is out of range; `err` is set and there is no wrap-around to index 0.
- `err` reset value is 0. It is not sticky.

## Test plan
- Reset, then SW `addr=0x0`, `WD=0x12345678`; next cycle LW `0x0` → `DM_WB=0x12345678`, `err=0`, log `@<pc>: *00000000 <= 12345678`.
- After the above, SB `addr=0x1`, `WD=0xFFFFFFAB` → word becomes `0x1234AB78`. LB `0x1` → `0xFFFFFFAB`; LBU `0x1` → `0x000000AB`.
- SH `addr=0x6`, `WD=0x00008001` → word 1 becomes `0x80010000`. LH `0x6` → `0xFFFF8001`; LHU `0x6` → `0x00008001`.
- Fault cases (each → `err=1` next cycle only, memory unchanged, load `DM_WB=0`):
  - SW `addr=0x2`.
  - LH `addr=0x3`.
  - LW `addr=4*DEPTH` (0x3000).
  - `DMop=101` with `MemWrite=1`.
- LW `0x2FFC` after SW `0x2FFC=0xDEADBEEF` → returns `0xDEADBEEF`.
- Assert `reset` mid-cycle with `MemWrite=1` to `0x0` → the store is dropped, `DM_WB` and `err` are 0 immediately, and after release LW `0x0` → 0.
